// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes, debounces and auto-repeats N_KEYS raw key inputs.
// Each channel gives a debounced level and a one-cycle press pulse. Held keys can
// also produce repeat pulses. key_code reports the lowest channel that is pulsing.
module key_conditioner #(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_PERIOD   = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_KEYS-1:0]         key_in,
    output logic [N_KEYS-1:0]         key_level,
    output logic [N_KEYS-1:0]         key_pulse,
    output logic                      key_valid,
    output logic [$clog2(N_KEYS)-1:0] key_code
);

    localparam int unsigned CodeW    = $clog2(N_KEYS);
    localparam int unsigned CntW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TimerMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                       : REPEAT_PERIOD;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);

    // Terminal counts. The timer restarts at 0 on entry to HOLD/RWAIT, so the
    // state is left on the edge where the timer already holds DELAY-2 or PERIOD-2.
    localparam logic [CntW-1:0]   CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TimerW-1:0] HoldLast = TimerW'(REPEAT_DELAY - 2);
    localparam logic [TimerW-1:0] WaitLast = TimerW'(REPEAT_PERIOD - 2);

    typedef enum logic [2:0] {
        StReady,
        StFirst,
        StHold,
        StRpulse,
        StRwait
    } state_e;

    logic [N_KEYS-1:0] s1_q;
    logic [N_KEYS-1:0] s2_q;
    logic [N_KEYS-1:0] level_all;
    logic [N_KEYS-1:0] pulse_all;
    logic [CodeW-1:0]  code;

    // Two-flop synchronizer for the asynchronous key inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= key_in;
            s2_q <= s1_q;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        logic [CntW-1:0]   cnt_q;
        logic [CntW-1:0]   cnt_d;
        logic              level_q;
        logic              level_d;
        state_e            state_q;
        state_e            state_d;
        logic [TimerW-1:0] timer_q;
        logic [TimerW-1:0] timer_d;
        logic              pulse;

        // Debounce: count consecutive disagreeing samples and adopt s2 on the last one.
        always_comb begin
            cnt_d   = '0;
            level_d = level_q;
            if (s2_q[i] != level_q) begin
                if (cnt_q == CntLast) begin
                    level_d = s2_q[i];
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        end

        // Debounce state register.
        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                level_q <= level_d;
            end
        end

        // FSM state and timer register.
        always_ff @(posedge clock) begin
            if (reset) begin
                state_q <= StReady;
                timer_q <= '0;
            end else begin
                state_q <= state_d;
                timer_q <= timer_d;
            end
        end

        // FSM next state. A low level always returns to READY, ahead of any timer expiry.
        always_comb begin
            state_d = state_q;
            timer_d = '0;
            if (!level_q) begin
                state_d = StReady;
            end else begin
                unique case (state_q)
                    StReady:  state_d = StFirst;
                    StFirst:  state_d = StHold;
                    StHold: begin
                        if (timer_q != HoldLast) begin
                            timer_d = timer_q + TimerW'(1);
                        end else if (REPEAT_EN != 0) begin
                            state_d = StRpulse;
                        end else begin
                            // Repeat disabled: park here with the timer saturated.
                            timer_d = timer_q;
                        end
                    end
                    StRpulse: state_d = StRwait;
                    StRwait: begin
                        if (timer_q == WaitLast) begin
                            state_d = StRpulse;
                        end else begin
                            timer_d = timer_q + TimerW'(1);
                        end
                    end
                    default:  state_d = StReady;
                endcase
            end
        end

        // FSM output: pulse decoded from the registered state only.
        always_comb begin
            pulse = (state_q == StFirst) || (state_q == StRpulse);
        end

        assign level_all[i] = level_q;
        assign pulse_all[i] = pulse;
    end

    // Priority encoder: the lowest pulsing channel wins, 0 when nothing pulses.
    always_comb begin
        code = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (pulse_all[i]) begin
                code = CodeW'(i);
            end
        end
    end

    // Outputs are forced quiet while reset is asserted.
    always_comb begin
        key_level = reset ? '0 : level_all;
        key_pulse = reset ? '0 : pulse_all;
        key_valid = reset ? 1'b0 : |pulse_all;
        key_code  = reset ? '0 : code;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed sequences and a table of simultaneous presses.
// Random key activity is also driven and compared every cycle against a
// behavioural model. Two instances share inputs: one with repeat enabled, one with
// repeat disabled.
module tb_key_conditioner;

    localparam int DB = 2;
    localparam int RD = 4;
    localparam int RP = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key_in = 4'b1111;

    logic [3:0] lvl_r, pul_r, lvl_n, pul_n;
    logic       val_r, val_n;
    logic [1:0] code_r, code_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    key_conditioner #(
        .N_KEYS(4), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) u_rep (
        .clock(clock), .reset(reset), .key_in(key_in),
        .key_level(lvl_r), .key_pulse(pul_r), .key_valid(val_r), .key_code(code_r)
    );

    key_conditioner #(
        .N_KEYS(4), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(0),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) u_norep (
        .clock(clock), .reset(reset), .key_in(key_in),
        .key_level(lvl_n), .key_pulse(pul_n), .key_valid(val_n), .key_code(code_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] low_idx(input logic [3:0] p);
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (p[i]) low_idx = 2'(i);
        end
    endfunction

    // Behavioural model. s2 is the input delayed by two edges. The level flips once the
    // last DB s2 samples all disagree with it. Pulses follow from how many edges the
    // level has been high: the first pulse is at age 1, then repeats at 1+RD, 1+RD+RP, ...
    logic [3:0] m_s1, m_s2, m_level, e_pul_r, e_pul_n;
    int         age [4];
    bit         hist [4][$];
    bit         model_live = 1'b0;
    bit         all_diff;

    always @(posedge clock) begin
        if (reset) begin
            model_live = 1'b1;
            m_s1 = '0;
            m_s2 = '0;
            m_level = '0;
            e_pul_r = '0;
            e_pul_n = '0;
            for (int ch = 0; ch < 4; ch++) begin
                age[ch] = 0;
                hist[ch].delete();
            end
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                if (m_level[ch]) age[ch]++;
                else age[ch] = 0;
                e_pul_r[ch] = (age[ch] == 1) ||
                              (age[ch] >= RD + 1 && (age[ch] - RD - 1) % RP == 0);
                e_pul_n[ch] = (age[ch] == 1);
                hist[ch].push_back(m_s2[ch]);
                if (hist[ch].size() > DB) void'(hist[ch].pop_front());
                if (hist[ch].size() == DB) begin
                    all_diff = 1'b1;
                    foreach (hist[ch][j]) if (hist[ch][j] == m_level[ch]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_level[ch] = ~m_level[ch];
                        hist[ch].delete();
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = key_in;
        end
    end

    logic [3:0] xr, xn, xl;
    always @(negedge clock) begin
        if (model_live) begin
            xr = reset ? 4'b0 : e_pul_r;
            xn = reset ? 4'b0 : e_pul_n;
            xl = reset ? 4'b0 : m_level;
            check("model_level_rep", lvl_r, xl);
            check("model_pulse_rep", pul_r, xr);
            check("model_valid_rep", val_r, |xr);
            check("model_code_rep", code_r, low_idx(xr));
            check("model_level_norep", lvl_n, xl);
            check("model_pulse_norep", pul_n, xn);
            check("model_valid_norep", val_n, |xn);
            check("model_code_norep", code_n, low_idx(xn));
        end
    end

    // Inputs change 1 time unit after a falling edge, clear of all sampling points.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic [3:0] k);
        #1 key_in = k;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    typedef struct packed {
        logic [3:0] keys;
        logic [3:0] exp_pulse;
        logic [1:0] exp_code;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{keys: 4'b1100, exp_pulse: 4'b1100, exp_code: 2'd2};
        vecs[1] = '{keys: 4'b0001, exp_pulse: 4'b0001, exp_code: 2'd0};
        vecs[2] = '{keys: 4'b1010, exp_pulse: 4'b1010, exp_code: 2'd1};
        vecs[3] = '{keys: 4'b1000, exp_pulse: 4'b1000, exp_code: 2'd3};
        vecs[4] = '{keys: 4'b0110, exp_pulse: 4'b0110, exp_code: 2'd1};
        vecs[5] = '{keys: 4'b1111, exp_pulse: 4'b1111, exp_code: 2'd0};

        // Keys held through reset: quiet during reset, then a fresh press after release.
        @(negedge clock);
        check("rst_pulse", pul_r, 4'b0);
        check("rst_level", lvl_r, 4'b0);
        @(negedge clock);
        check("rst_valid", val_r, 1'b0);
        check("rst_code", code_r, 2'd0);
        #1 reset = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            tick();
            check("rel_pulse_rep", pul_r, (c == 4) ? 4'b1111 : 4'b0000);
            check("rel_pulse_norep", pul_n, (c == 4) ? 4'b1111 : 4'b0000);
            check("rel_valid", val_r, c == 4);
            check("rel_code", code_r, 2'd0);
            check("rel_level", lvl_r, (c >= 3) ? 4'b1111 : 4'b0000);
        end
        drive(4'b0000);
        idle(12);

        // Single key held 20 cycles: first pulse then repeats, or one pulse without repeat.
        drive(4'b0010);
        for (int c = 0; c <= 21; c++) begin
            tick();
            check("hold_pulse_rep", pul_r[1], c inside {4, 8, 11, 14, 17, 20});
            check("hold_pulse_norep", pul_n[1], c == 4);
            if (pul_r[1]) check("hold_code", code_r, 2'd1);
            if (c >= 3) check("hold_level_norep", lvl_n[1], 1'b1);
            if (c == 19) drive(4'b0000);
        end
        idle(12);

        // Input toggling every cycle never gets past the debouncer.
        for (int c = 0; c <= 13; c++) begin
            drive({3'b000, (c < 8) && (c % 2 == 0)});
            tick();
            check("bounce_pulse", pul_r[0], 1'b0);
            check("bounce_level", lvl_r[0], 1'b0);
        end
        idle(4);

        // Simultaneous presses from a table.
        for (int v = 0; v < 6; v++) begin
            drive(vecs[v].keys);
            for (int c = 0; c <= 5; c++) begin
                tick();
                check("tab_pulse_rep", pul_r, (c == 4) ? vecs[v].exp_pulse : 4'b0);
                check("tab_pulse_norep", pul_n, (c == 4) ? vecs[v].exp_pulse : 4'b0);
                check("tab_valid", val_r, c == 4);
                if (c == 4) check("tab_code", code_r, vecs[v].exp_code);
            end
            drive(4'b0000);
            idle(12);
        end

        // Release during HOLD, re-press after 5 low samples: no release pulse, fresh timing.
        drive(4'b0100);
        for (int c = 0; c <= 19; c++) begin
            tick();
            check("repress_pulse_rep", pul_r[2], c inside {4, 13, 17});
            check("repress_pulse_norep", pul_n[2], c inside {4, 13});
            if (c == 8) check("repress_level_low", lvl_r[2], 1'b0);
            if (c <= 2 || c >= 8) drive(4'b0100);
            else drive(4'b0000);
        end
        drive(4'b0000);
        idle(12);

        // Reset during a repeat pulse aborts it; the held key then behaves as a new press.
        drive(4'b0001);
        for (int c = 0; c <= 8; c++) tick();
        check("pre_abort_pulse", pul_r[0], 1'b1);
        #1 reset = 1'b1;
        tick();
        #1 reset = 1'b0;
        #1;
        check("abort_pulse_rep", pul_r, 4'b0);
        check("abort_pulse_norep", pul_n, 4'b0);
        check("abort_level", lvl_r, 4'b0);
        check("abort_valid", val_r, 1'b0);
        for (int c = 0; c <= 5; c++) begin
            tick();
            check("post_abort_pulse", pul_r[0], c == 4);
        end
        drive(4'b0000);
        idle(12);

        // Random key activity with occasional resets, checked by the model every cycle.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clock);
            #1;
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 5) == 0) key_in[ch] = ~key_in[ch];
            end
            reset = ($urandom_range(0, 249) == 0);
        end
        @(negedge clock);
        #1;
        reset = 1'b0;
        key_in = 4'b0000;
        idle(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
